// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - EX-stage to divider handshake bundle
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 signed_div;
  logic [WIDTH-1:0]     opdata1;
  logic [WIDTH-1:0]     opdata2;
  logic                 annul;
  logic [2*WIDTH-1:0]   result;
  logic                 ready;
  logic                 stall;
  logic                 div_by_zero;

  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  result, ready, stall, div_by_zero
  );

  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output result, ready, stall, div_by_zero
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU
// DIV_BYZERO_DETECT_EN: short-circuit a zero divisor to a zero result with div_by_zero set.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

`ifdef DIV_BYZERO_DETECT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, END = 2'd2, BYZERO = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, END = 2'd2} state_t;
`endif

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;
`ifdef DIV_BYZERO_DETECT_EN
  logic                 zero_q, zero_d;
  logic                 dbz_q, dbz_d;
`endif

  logic [WIDTH-1:0]     abs1, abs2, quo_fix, rem_fix;
  logic [WIDTH:0]       rem_shift, rem_sub;
  logic                 op1_neg, op2_neg;

  always_comb begin
    op1_neg   = bus.signed_div & bus.opdata1[WIDTH-1];
    op2_neg   = bus.signed_div & bus.opdata2[WIDTH-1];
    abs1      = op1_neg ? -bus.opdata1 : bus.opdata1;
    abs2      = op2_neg ? -bus.opdata2 : bus.opdata2;
    // Quotient bits are shifted into quo_q as dividend bits are consumed from its top.
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    quo_fix   = neg_quo_q ? -quo_q : quo_q;
    rem_fix   = neg_rem_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
`ifdef DIV_BYZERO_DETECT_EN
    zero_d    = zero_q;
    dbz_d     = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.annul) begin
          quo_d     = abs1;
          dvs_d     = abs2;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = bus.signed_div & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
          neg_rem_d = bus.signed_div & bus.opdata1[WIDTH-1];
          state_d   = ON;
`ifdef DIV_BYZERO_DETECT_EN
          zero_d    = (bus.opdata2 == '0);
          if (bus.opdata2 == '0) state_d = BYZERO;
`endif
        end
      end
`ifdef DIV_BYZERO_DETECT_EN
      BYZERO: state_d = END;
`endif
      ON: begin
        if (rem_shift >= {1'b0, dvs_q}) begin
          rem_d = rem_sub[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = END;
      end
      END: begin
        if (bus.start) begin
          ready_d  = 1'b1;
          result_d = {rem_fix, quo_fix};
`ifdef DIV_BYZERO_DETECT_EN
          if (zero_q) result_d = '0;
          dbz_d = zero_q;
`endif
        end else begin
          // An abandoned request leaves the previous result in place.
          state_d = IDLE;
          ready_d = 1'b0;
`ifdef DIV_BYZERO_DETECT_EN
          dbz_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.annul && state_q != IDLE) begin
      state_d  = IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
`ifdef DIV_BYZERO_DETECT_EN
      dbz_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
`ifdef DIV_BYZERO_DETECT_EN
      zero_q    <= 1'b0;
      dbz_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
`ifdef DIV_BYZERO_DETECT_EN
      zero_q    <= zero_d;
      dbz_q     <= dbz_d;
`endif
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = ready_q;
  assign bus.stall  = bus.start & ~ready_q;
`ifdef DIV_BYZERO_DETECT_EN
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus();
  div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    string        name;
    bit           s;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [63:0]  exp;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
`ifdef DIV_BYZERO_DETECT_EN
    if (b == 32'd0) return 64'h0;
`endif
    ua = (s && a[31]) ? 32'd0 - a : a;
    ub = (s && b[31]) ? 32'd0 - b : b;
    if (ub == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = ua;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (s && (a[31] ^ b[31])) q = 32'd0 - q;
    if (s && a[31]) r = 32'd0 - r;
    return {r, q};
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_BYZERO_DETECT_EN
    if (b == 32'd0) return 3;
`endif
    return 34;
  endfunction

  function automatic logic exp_dbz(input logic [31:0] b);
`ifdef DIV_BYZERO_DETECT_EN
    return (b == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_div(input string name, input bit s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    int n;
    bit stall_ok;
    logic [63:0] res;
    stall_ok = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.signed_div = s;
    bus.opdata1 = a;
    bus.opdata2 = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.ready && !bus.stall) stall_ok = 1'b0;
      bus.opdata1 = $urandom;
      bus.opdata2 = $urandom;
      bus.signed_div = 1'($urandom);
    end while (!bus.ready && n < 100);
    res = bus.result;
    chk({name, "/latency"}, 64'(n), 64'(exp_lat(b)));
    chk({name, "/result"}, res, exp);
    chk({name, "/dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz(b)));
    chk({name, "/stall_while_busy"}, 64'(stall_ok), 64'd1);
    chk({name, "/stall_at_ready"}, 64'(bus.stall), 64'd0);
    repeat (2) @(negedge clk);
    chk({name, "/ready_hold"}, 64'(bus.ready), 64'd1);
    chk({name, "/result_hold"}, bus.result, exp);
    bus.start = 1'b0;
    @(negedge clk);
    chk({name, "/ready_drop"}, 64'(bus.ready), 64'd0);
    chk({name, "/result_kept"}, bus.result, exp);
    chk({name, "/dbz_drop"}, 64'(bus.div_by_zero), 64'd0);
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1 = a;
    bus.opdata2 = b;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [63:0] prev;
    int seen;
    bit s;
    logic [31:0] a, b;

    tbl[0] = '{"divu_100_7",    1'b0, 32'd100,       32'd7,         64'h00000002_0000000E};
    tbl[1] = '{"div_m7_2",      1'b1, 32'hFFFFFFF9,  32'h00000002,  64'hFFFFFFFF_FFFFFFFD};
    tbl[2] = '{"div_7_m2",      1'b1, 32'h00000007,  32'hFFFFFFFE,  64'h00000001_FFFFFFFD};
    tbl[3] = '{"div_min_m1",    1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000};
    tbl[4] = '{"divu_min_m1",   1'b0, 32'h80000000,  32'hFFFFFFFF,  64'h80000000_00000000};
`ifdef DIV_BYZERO_DETECT_EN
    tbl[5] = '{"divu_5_0",      1'b0, 32'd5,         32'd0,         64'h0};
`else
    tbl[5] = '{"divu_5_0",      1'b0, 32'd5,         32'd0,         64'h00000005_FFFFFFFF};
`endif

    rst = 1'b1;
    bus.start = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1 = '0;
    bus.opdata2 = '0;
    bus.annul = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset/result", bus.result, 64'h0);
    chk("reset/ready", 64'(bus.ready), 64'd0);
    chk("reset/dbz", 64'(bus.div_by_zero), 64'd0);
    chk("reset/stall", 64'(bus.stall), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_div(tbl[i].name, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].exp);

    // Annul mid-division: nothing completes, result untouched.
    run_div("pre_annul", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    prev = bus.result;
    launch(32'd123, 32'd4);
    bus.annul = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.annul = 1'b0;
    chk("annul/ready", 64'(bus.ready), 64'd0);
    chk("annul/result", bus.result, prev);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready) seen++;
    end
    chk("annul/no_ready", 64'(seen), 64'd0);
    run_div("post_annul", 1'b0, 32'd123, 32'd4, ref_div(1'b0, 32'd123, 32'd4));

    // Start withdrawn mid-division: the result is discarded.
    prev = bus.result;
    launch(32'd999, 32'd10);
    bus.start = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready) seen++;
    end
    chk("withdraw/no_ready", 64'(seen), 64'd0);
    chk("withdraw/result", bus.result, prev);

    // Reset mid-division.
    launch(32'd77, 32'd3);
    rst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("midrst/result", bus.result, 64'h0);
    chk("midrst/ready", 64'(bus.ready), 64'd0);
    chk("midrst/dbz", 64'(bus.div_by_zero), 64'd0);
    rst = 1'b0;
    run_div("post_rst", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF);

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = (($urandom & 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_div($sformatf("rand%0d", i), s, a, b, ref_div(s, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
- Sits in the EX stage directly upstream of the ALU. Its 64-bit result drives the ALU's div_res input, which the ALU writes into HI/LO.
- Asserts stall to freeze the pipeline while a division is in flight.

Parameters:
- WIDTH, 32, operand width in bits. Result is 2*WIDTH; iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division. Held high by the EX stage until ready is seen.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU. Sampled with start.
- opdata1  input  WIDTH  dividend (rs). Sampled with start.
- opdata2  input  WIDTH  divisor (rt). Sampled with start.
- annul  input  1  pipeline flush or exception; aborts the current division.
- result  output  2*WIDTH  {remainder, quotient}; upper half goes to HI, lower half to LO.
- ready  output  1  result valid.
- stall  output  1  combinational: start & ~ready.
- div_by_zero  output  1  divisor was zero; see Optional Feature.

Behaviour:
- Reset: state=IDLE, result=0, ready=0, div_by_zero=0, counter=0, internal registers=0. Reset has priority over everything, including mid-operation; no partial result is kept.
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - start=1 and annul=0 → latch operands and signed_div, go to ON with counter=0.
  - When signed_div=1, convert each negative operand to its two's-complement magnitude.
  - Save sign_q = opdata1[31]^opdata2[31] and sign_r = opdata1[31].
- ON, one iteration per cycle:
  - Shift the partial remainder left, bringing in the next dividend MSB.
  - If the partial remainder is >= |divisor|, subtract and shift in quotient bit 1; otherwise shift in 0.
  - counter increments; after WIDTH iterations (counter==WIDTH-1 done) go to END.
- END:
  - result = {remainder, quotient}, with sign correction when signed: quotient negated if sign_q; remainder negated if sign_r.
  - ready=1.
  - Stay in END while start=1; return to IDLE when start=0, clearing ready. result holds its value until the next start.
- Latency: start sampled in IDLE at edge N → ready=1 in the cycle after edge N+33, i.e. 33 cycles of stall.
- annul=1 in any state except IDLE → go to IDLE next edge; ready=0; result unchanged. annul has priority over start and over ON→END.
- start deasserted during ON (without annul): the division completes anyway; the result is discarded when END is exited.
- Operand inputs are ignored outside IDLE, so a late operand change does not corrupt an in-flight division.
- Signed arithmetic rules:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0; no trap is raised.
- Divide by zero when the macro is not defined: runs the normal 32 iterations. Unsigned yields quotient 0xFFFFFFFF, remainder = dividend. Signed yields the sign-corrected result of the same algorithm. div_by_zero is tied to 0.

Optional Feature:
- Macro: DIV_BYZERO_DETECT_EN.
- Defined:
  - In IDLE, start with opdata2==0 goes to BYZERO instead of ON.
  - BYZERO lasts one cycle, then END with result=64'h0 and div_by_zero=1.
  - ready is high in the cycle after edge N+2.
  - div_by_zero clears when END is exited.
- Not defined: no BYZERO state; divide by zero follows the normal iteration path; div_by_zero is a constant 0.

Test Plan:
- DIVU 100/7 (opdata1=32'd100, opdata2=32'd7, start held) → stall=1 for 33 cycles, then ready=1 with result=64'h00000002_0000000E; drop start → ready=0 next cycle.
- DIV -7/2 (32'hFFFFFFF9, 32'h00000002) → result=64'hFFFFFFFF_FFFFFFFD. DIV 7/-2 → result=64'h00000001_FFFFFFFD.
- DIV 32'h80000000 / 32'hFFFFFFFF → result=64'h00000000_80000000, no hang. DIVU same operands → result=64'h80000000_00000000.
- annul pulsed 10 cycles after start → IDLE next edge, ready never asserts. A new start then gives the correct result 33 cycles later.
- rst asserted mid-ON → all outputs 0 next edge. A fresh DIVU 0xFFFFFFFF/0x10 → result=64'h0000000F_0FFFFFFF.
- DIVU 5/0:
  - Macro on → ready after 2 cycles, result=0, div_by_zero=1.
  - Macro off → ready after 33 cycles, result=64'h00000005_FFFFFFFF, div_by_zero=0.
